// File: rtl/cluster_addr_map_pkg.sv
// Shared definitions for the cluster address-map controller: register map,
// FSM states, reset-map offsets, STATUS layout and the crossbar rule type.
package cluster_addr_map_pkg;

  typedef enum logic [2:0] {
    REG_R0_START = 3'd0,
    REG_R0_END   = 3'd1,
    REG_R1_START = 3'd2,
    REG_R1_END   = 3'd3,
    REG_DEFAULT  = 3'd4,
    REG_COMMIT   = 3'd5,
    REG_STATUS   = 3'd6,
    REG_UNMAPPED = 3'd7
  } reg_idx_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_COMMIT
  } state_e;

  localparam logic [31:0] DEFAULT_BASE   = 32'h1000_0000;
  localparam int unsigned CLUSTER_SHIFT  = 22;
  localparam logic [31:0] R0_END_OFS     = 32'h0010_0000;
  localparam logic [31:0] R1_START_OFS   = 32'h0020_0000;
  localparam logic [31:0] R1_END_OFS     = 32'h0040_0000;
  localparam int unsigned DEFAULT_PORT   = 2;
  localparam int unsigned DEFAULT_EN_BIT = 8;

  localparam int unsigned STAT_BUSY      = 0;
  localparam int unsigned STAT_PENDING   = 1;
  localparam int unsigned STAT_UNDERFLOW = 2;
  localparam int unsigned STAT_REJECT    = 3;
  localparam int unsigned STAT_CNT_LSB   = 8;

  // Same field layout as the crossbar's 32-bit address rule.
  typedef struct packed {
    logic [31:0] idx;
    logic [31:0] start_addr;
    logic [31:0] end_addr;
  } xbar_rule_32_t;

  function automatic logic [31:0] cluster_base(input logic [5:0] cluster_id);
    return DEFAULT_BASE + ({26'd0, cluster_id} << CLUSTER_SHIFT);
  endfunction

  // True when either rule is empty/inverted or the two ranges intersect.
  function automatic logic rules_invalid(input logic [31:0] s0, input logic [31:0] e0,
                                         input logic [31:0] s1, input logic [31:0] e1);
    return (s0 >= e0) || (s1 >= e1) || ((s0 < e1) && (s1 < e0));
  endfunction

endpackage

// File: rtl/cluster_outstanding_cnt.sv
// Outstanding AXI transaction counter: net per-cycle update of issued minus
// completed transactions, clamped at zero with an underflow pulse.
module cluster_outstanding_cnt #(
  parameter int unsigned NB_SLV_PORTS = 3,
  parameter int unsigned CNT_WIDTH    = 6
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NB_SLV_PORTS-1:0] aw_hs_i,
  input  logic [NB_SLV_PORTS-1:0] ar_hs_i,
  input  logic [NB_SLV_PORTS-1:0] b_hs_i,
  input  logic [NB_SLV_PORTS-1:0] rlast_hs_i,
  output logic [CNT_WIDTH-1:0]    cnt_o,
  output logic                    underflow_o
);

  localparam int unsigned SW = CNT_WIDTH + $clog2(NB_SLV_PORTS + 1) + 1;

  logic [SW-1:0]        inc, dec, sum;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    inc = '0;
    dec = '0;
    for (int i = 0; i < int'(NB_SLV_PORTS); i++) begin
      inc = inc + SW'(aw_hs_i[i] | ar_hs_i[i]);
      dec = dec + SW'(b_hs_i[i] | rlast_hs_i[i]);
    end
    sum         = SW'(cnt_q) + inc;
    underflow_o = (sum < dec);
    cnt_d       = underflow_o ? '0 : CNT_WIDTH'(sum - dec);
  end

  // NOTE: sequential state uses non-blocking assignments; reset is synchronous.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/cluster_addr_map_ctrl.sv
// Shadow/active crossbar address-map controller with drain-then-commit FSM.
// Optional CLUSTER_ADDR_MAP_CHECK_EN rejects commits of empty/overlapping rules.
module cluster_addr_map_ctrl
  import cluster_addr_map_pkg::*;
#(
  parameter int unsigned NB_SLV_PORTS = 3,
  parameter int unsigned NB_MST_PORTS = 3,
  parameter int unsigned CNT_WIDTH    = 6
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [5:0]                      cluster_id_i,
  input  logic                            cfg_req_i,
  input  logic                            cfg_we_i,
  input  logic [2:0]                      cfg_addr_i,
  input  logic [31:0]                     cfg_wdata_i,
  output logic                            cfg_gnt_o,
  output logic                            cfg_rvalid_o,
  output logic [31:0]                     cfg_rdata_o,
  output logic                            cfg_err_o,
  input  logic [NB_SLV_PORTS-1:0]         aw_hs_i,
  input  logic [NB_SLV_PORTS-1:0]         ar_hs_i,
  input  logic [NB_SLV_PORTS-1:0]         b_hs_i,
  input  logic [NB_SLV_PORTS-1:0]         rlast_hs_i,
  output logic                            req_block_o,
  output xbar_rule_32_t [1:0]             addr_map_o,
  output logic [$clog2(NB_MST_PORTS)-1:0] default_mst_port_o,
  output logic                            en_default_o,
  output logic                            busy_o
);

  localparam int unsigned DPW = $clog2(NB_MST_PORTS);

  typedef struct packed {
    logic [31:0]    r0_start;
    logic [31:0]    r0_end;
    logic [31:0]    r1_start;
    logic [31:0]    r1_end;
    logic [DPW-1:0] dflt_port;
    logic           dflt_en;
  } map_cfg_t;

  map_cfg_t             shadow_q, active_q, reset_map;
  state_e               state_q, state_d;
  reg_idx_e             addr;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 underflow, underflow_q, reject, reject_q;
  logic                 busy_q, rvalid_q, err_q, err_d;
  logic [31:0]          rdata_q, rdata_d, base;
  logic                 wr_acc, rd_acc, commit_wr, commit_go, any_hs;

  cluster_outstanding_cnt #(
    .NB_SLV_PORTS(NB_SLV_PORTS),
    .CNT_WIDTH   (CNT_WIDTH)
  ) u_cnt (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .aw_hs_i    (aw_hs_i),
    .ar_hs_i    (ar_hs_i),
    .b_hs_i     (b_hs_i),
    .rlast_hs_i (rlast_hs_i),
    .cnt_o      (cnt),
    .underflow_o(underflow)
  );

  always_comb begin
    base                = cluster_base(cluster_id_i);
    reset_map.r0_start  = base;
    reset_map.r0_end    = base + R0_END_OFS;
    reset_map.r1_start  = base + R1_START_OFS;
    reset_map.r1_end    = base + R1_END_OFS;
    reset_map.dflt_port = DPW'(DEFAULT_PORT);
    reset_map.dflt_en   = 1'b1;
  end

  // Reads are always granted; writes only while no commit is in flight.
  assign addr      = reg_idx_e'(cfg_addr_i);
  assign cfg_gnt_o = cfg_req_i & (~cfg_we_i | (state_q == ST_IDLE));
  assign wr_acc    = cfg_gnt_o & cfg_we_i;
  assign rd_acc    = cfg_gnt_o & ~cfg_we_i;
  assign commit_wr = wr_acc & (addr == REG_COMMIT) & cfg_wdata_i[0];
  assign any_hs    = |{aw_hs_i, ar_hs_i, b_hs_i, rlast_hs_i};
  assign commit_go = (state_q == ST_DRAIN) && (cnt == '0) && !any_hs;

`ifdef CLUSTER_ADDR_MAP_CHECK_EN
  assign reject = commit_wr & rules_invalid(shadow_q.r0_start, shadow_q.r0_end,
                                            shadow_q.r1_start, shadow_q.r1_end);
`else
  assign reject = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (commit_wr && !reject) state_d = ST_DRAIN;
      ST_DRAIN:  if (commit_go) state_d = ST_COMMIT;
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rdata_d = '0;
    err_d   = 1'b0;
    case (addr)
      REG_R0_START: rdata_d = shadow_q.r0_start;
      REG_R0_END:   rdata_d = shadow_q.r0_end;
      REG_R1_START: rdata_d = shadow_q.r1_start;
      REG_R1_END:   rdata_d = shadow_q.r1_end;
      REG_DEFAULT: begin
        rdata_d[DPW-1:0]       = shadow_q.dflt_port;
        rdata_d[DEFAULT_EN_BIT] = shadow_q.dflt_en;
      end
      REG_COMMIT:   rdata_d = '0;
      REG_STATUS: begin
        rdata_d[STAT_BUSY]                   = busy_q;
        rdata_d[STAT_PENDING]                = (state_q == ST_DRAIN);
        rdata_d[STAT_UNDERFLOW]              = underflow_q;
        rdata_d[STAT_REJECT]                 = reject_q;
        rdata_d[STAT_CNT_LSB +: CNT_WIDTH]   = cnt;
      end
      default:      err_d = 1'b1;
    endcase
    if (cfg_we_i) begin
      rdata_d = '0;
      err_d   = (addr == REG_STATUS) || (addr == REG_UNMAPPED) || reject;
    end
  end

  // NOTE: the map registers are real flops with a reset value (cluster-dependent
  // defaults), not a memory, so they are loaded on every reset edge.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      shadow_q    <= reset_map;
      active_q    <= reset_map;
      busy_q      <= 1'b0;
      rvalid_q    <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      underflow_q <= 1'b0;
      reject_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      busy_q   <= (state_d != ST_IDLE);
      rvalid_q <= cfg_gnt_o;
      err_q    <= cfg_gnt_o & err_d;
      rdata_q  <= rd_acc ? rdata_d : '0;
      if (underflow) underflow_q <= 1'b1;
      if (reject)    reject_q    <= 1'b1;
      // Active map switches on entry to COMMIT, so it is live while still blocked.
      if (commit_go) active_q <= shadow_q;
      if (wr_acc) begin
        case (addr)
          REG_R0_START: shadow_q.r0_start <= cfg_wdata_i;
          REG_R0_END:   shadow_q.r0_end   <= cfg_wdata_i;
          REG_R1_START: shadow_q.r1_start <= cfg_wdata_i;
          REG_R1_END:   shadow_q.r1_end   <= cfg_wdata_i;
          REG_DEFAULT: begin
            shadow_q.dflt_port <= cfg_wdata_i[DPW-1:0];
            shadow_q.dflt_en   <= cfg_wdata_i[DEFAULT_EN_BIT];
          end
          default: ;
        endcase
      end
    end
  end

  assign cfg_rvalid_o       = rvalid_q;
  assign cfg_rdata_o        = rdata_q;
  assign cfg_err_o          = err_q;
  assign busy_o             = busy_q;
  assign req_block_o        = busy_q;
  assign addr_map_o[0]      = '{idx: 32'd0, start_addr: active_q.r0_start, end_addr: active_q.r0_end};
  assign addr_map_o[1]      = '{idx: 32'd1, start_addr: active_q.r1_start, end_addr: active_q.r1_end};
  assign default_mst_port_o = active_q.dflt_port;
  assign en_default_o       = active_q.dflt_en;

endmodule

// File: tb/tb_cluster_addr_map_ctrl.sv
// Scoreboard bench for cluster_addr_map_ctrl: config responses are queued at
// issue time and checked by an independent monitor on cfg_rvalid_o.
module tb_cluster_addr_map_ctrl;
  import cluster_addr_map_pkg::*;

`ifdef CLUSTER_ADDR_MAP_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst_n;
  logic [5:0]          cluster_id;
  logic                cfg_req, cfg_we;
  logic [2:0]          cfg_addr;
  logic [31:0]         cfg_wdata;
  logic                cfg_gnt, cfg_rvalid, cfg_err;
  logic [31:0]         cfg_rdata;
  logic [2:0]          aw_hs, ar_hs, b_hs, rlast_hs;
  logic                req_block, en_default, busy;
  xbar_rule_32_t [1:0] addr_map;
  logic [1:0]          default_mst_port;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t exp_q[$];

  cluster_addr_map_ctrl dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .cluster_id_i      (cluster_id),
    .cfg_req_i         (cfg_req),
    .cfg_we_i          (cfg_we),
    .cfg_addr_i        (cfg_addr),
    .cfg_wdata_i       (cfg_wdata),
    .cfg_gnt_o         (cfg_gnt),
    .cfg_rvalid_o      (cfg_rvalid),
    .cfg_rdata_o       (cfg_rdata),
    .cfg_err_o         (cfg_err),
    .aw_hs_i           (aw_hs),
    .ar_hs_i           (ar_hs),
    .b_hs_i            (b_hs),
    .rlast_hs_i        (rlast_hs),
    .req_block_o       (req_block),
    .addr_map_o        (addr_map),
    .default_mst_port_o(default_mst_port),
    .en_default_o      (en_default),
    .busy_o            (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push_exp(input string name, input logic [31:0] rdata, input logic err);
    exp_t e;
    e.name  = name;
    e.rdata = rdata;
    e.err   = err;
    exp_q.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic cfg_access(input string name, input logic we, input logic [2:0] addr,
                            input logic [31:0] wdata, input logic [31:0] exp_rdata,
                            input logic exp_err);
    int waited = 0;
    cfg_req = 1'b1; cfg_we = we; cfg_addr = addr; cfg_wdata = wdata;
    #1;
    while (!cfg_gnt && waited < 50) begin
      @(negedge clk); #1;
      waited++;
    end
    check({name, "_gnt"}, cfg_gnt, 1'b1);
    if (cfg_gnt) push_exp(name, exp_rdata, exp_err);
    @(negedge clk);
    cfg_req = 1'b0; cfg_we = 1'b0;
  endtask

  task automatic pulse_hs(input logic [2:0] aw, input logic [2:0] ar,
                          input logic [2:0] b, input logic [2:0] rl);
    aw_hs = aw; ar_hs = ar; b_hs = b; rlast_hs = rl;
    @(negedge clk);
    aw_hs = '0; ar_hs = '0; b_hs = '0; rlast_hs = '0;
  endtask

  // Response monitor.
  always @(negedge clk) begin
    if (cfg_rvalid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: rvalid with rdata 0x%08h, expected no response", cfg_rdata);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check({e.name, "_rdata"}, cfg_rdata, e.rdata);
        check({e.name, "_err"}, cfg_err, e.err);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; cluster_id = 6'd1;
    cfg_req = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    aw_hs = '0; ar_hs = '0; b_hs = '0; rlast_hs = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset state for cluster 1.
    check("rst_r0_idx",   addr_map[0].idx,        32'd0);
    check("rst_r0_start", addr_map[0].start_addr, 32'h1040_0000);
    check("rst_r0_end",   addr_map[0].end_addr,   32'h1050_0000);
    check("rst_r1_idx",   addr_map[1].idx,        32'd1);
    check("rst_r1_start", addr_map[1].start_addr, 32'h1060_0000);
    check("rst_r1_end",   addr_map[1].end_addr,   32'h1080_0000);
    check("rst_port",     default_mst_port, 2);
    check("rst_en",       en_default, 1);
    check("rst_block",    req_block, 0);
    check("rst_busy",     busy, 0);
    check("rst_rvalid",   cfg_rvalid, 0);
    check("rst_rdata",    cfg_rdata, 0);
    cfg_access("rd_status0", 1'b0, REG_STATUS, 0, 32'h0, 1'b0);
    cfg_access("rd_r1_end",  1'b0, REG_R1_END, 0, 32'h1080_0000, 1'b0);
    cfg_access("rd_unmap",   1'b0, REG_UNMAPPED, 0, 32'h0, 1'b1);
    cfg_access("wr_status",  1'b1, REG_STATUS, 32'hFFFF_FFFF, 32'h0, 1'b1);
    cfg_access("wr_unmap",   1'b1, REG_UNMAPPED, 32'h1, 32'h0, 1'b1);
    cfg_access("rd_status1", 1'b0, REG_STATUS, 0, 32'h0, 1'b0);

    // Cluster 0, shadow update then minimum-latency commit.
    rst_n = 1'b0; cluster_id = 6'd0;
    @(negedge clk);
    rst_n = 1'b1;
    cfg_access("wr_r0_end",  1'b1, REG_R0_END, 32'h1008_0000, 32'h0, 1'b0);
    cfg_access("wr_default", 1'b1, REG_DEFAULT, 32'h0000_0001, 32'h0, 1'b0);
    cfg_access("rd_default", 1'b0, REG_DEFAULT, 0, 32'h0000_0001, 1'b0);
    check("shadow_only_r0_end", addr_map[0].end_addr, 32'h1010_0000);
    check("shadow_only_port",   default_mst_port, 2);
    cfg_req = 1'b1; cfg_we = 1'b1; cfg_addr = REG_COMMIT; cfg_wdata = 32'h1;
    #1;
    check("commit_gnt", cfg_gnt, 1);
    push_exp("commit0", 32'h0, 1'b0);
    check("commit_pre_block", req_block, 0);
    @(negedge clk);
    cfg_req = 1'b0; cfg_we = 1'b0;
    check("commit_c1_block", req_block, 1);
    check("commit_c1_busy",  busy, 1);
    check("commit_c1_map",   addr_map[0].end_addr, 32'h1010_0000);
    @(negedge clk);
    check("commit_c2_block", req_block, 1);
    check("commit_c2_map",   addr_map[0].end_addr, 32'h1008_0000);
    check("commit_c2_port",  default_mst_port, 1);
    check("commit_c2_en",    en_default, 0);
    @(negedge clk);
    check("commit_c3_block", req_block, 0);
    check("commit_c3_busy",  busy, 0);

    // Counter: per-port OR, same-cycle net update, underflow clamp.
    pulse_hs(3'b001, 3'b001, 3'b000, 3'b000);
    pulse_hs(3'b011, 3'b000, 3'b100, 3'b000);
    cfg_access("rd_cnt2", 1'b0, REG_STATUS, 0, 32'h0000_0200, 1'b0);
    pulse_hs(3'b000, 3'b000, 3'b011, 3'b001);
    cfg_access("rd_cnt0", 1'b0, REG_STATUS, 0, 32'h0000_0000, 1'b0);
    pulse_hs(3'b000, 3'b000, 3'b001, 3'b000);
    cfg_access("rd_uflow", 1'b0, REG_STATUS, 0, 32'h0000_0004, 1'b0);

    // Commit with three writes outstanding; a write stalls during the drain.
    cfg_access("wr_r1_end_a", 1'b1, REG_R1_END, 32'h1050_0000, 32'h0, 1'b0);
    pulse_hs(3'b111, 3'b000, 3'b000, 3'b000);
    cfg_access("commit1", 1'b1, REG_COMMIT, 32'h1, 32'h0, 1'b0);
    cfg_access("rd_drain_status", 1'b0, REG_STATUS, 0, 32'h0000_0307, 1'b0);
    cfg_req = 1'b1; cfg_we = 1'b1; cfg_addr = REG_R1_END; cfg_wdata = 32'h1060_0000;
    b_hs = 3'b001;
    #1;
    check("drain_stall_0", cfg_gnt, 0);
    @(negedge clk); b_hs = 3'b010;
    check("drain_stall_1", cfg_gnt, 0);
    @(negedge clk); b_hs = 3'b100;
    check("drain_stall_2", cfg_gnt, 0);
    @(negedge clk); b_hs = 3'b000;
    check("drain_last_block", req_block, 1);
    check("drain_last_stall", cfg_gnt, 0);
    check("drain_last_map",   addr_map[1].end_addr, 32'h1040_0000);
    @(negedge clk);
    check("drain_commit_map",   addr_map[1].end_addr, 32'h1050_0000);
    check("drain_commit_block", req_block, 1);
    check("drain_commit_stall", cfg_gnt, 0);
    @(negedge clk);
    check("drain_idle_block", req_block, 0);
    check("drain_idle_gnt",   cfg_gnt, 1);
    if (cfg_gnt) push_exp("wr_r1_end_b", 32'h0, 1'b0);
    @(negedge clk);
    cfg_req = 1'b0; cfg_we = 1'b0;
    cfg_access("rd_r1_end_b", 1'b0, REG_R1_END, 0, 32'h1060_0000, 1'b0);
    check("held_wr_shadow_only", addr_map[1].end_addr, 32'h1050_0000);

    // Overlapping rule1: rejected only when checking is compiled in.
    cfg_access("wr_r1_start_ovl", 1'b1, REG_R1_START, 32'h1000_8000, 32'h0, 1'b0);
    cfg_access("commit_ovl", 1'b1, REG_COMMIT, 32'h1, 32'h0, CHECK_EN);
    check("ovl_block", req_block, CHECK_EN ? 1'b0 : 1'b1);
    repeat (3) @(negedge clk);
    check("ovl_map", addr_map[1].start_addr, CHECK_EN ? 32'h1020_0000 : 32'h1000_8000);
    cfg_access("rd_ovl_status", 1'b0, REG_STATUS, 0, CHECK_EN ? 32'h0000_000C : 32'h0000_0004, 1'b0);

    // Reset while draining abandons the commit.
    cfg_access("wr_r1_start_fix", 1'b1, REG_R1_START, 32'h1020_0000, 32'h0, 1'b0);
    cfg_access("wr_r0_start",     1'b1, REG_R0_START, 32'h1000_4000, 32'h0, 1'b0);
    pulse_hs(3'b001, 3'b000, 3'b000, 3'b000);
    cfg_access("commit_rst", 1'b1, REG_COMMIT, 32'h1, 32'h0, 1'b0);
    check("rst_drain_block", req_block, 1);
    rst_n = 1'b0; cluster_id = 6'd2;
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_drain_block_clr", req_block, 0);
    check("rst_drain_busy_clr",  busy, 0);
    check("rst_drain_r0_start",  addr_map[0].start_addr, 32'h1080_0000);
    check("rst_drain_r0_end",    addr_map[0].end_addr,   32'h1090_0000);
    check("rst_drain_r1_start",  addr_map[1].start_addr, 32'h10A0_0000);
    check("rst_drain_r1_end",    addr_map[1].end_addr,   32'h10C0_0000);
    check("rst_drain_port",      default_mst_port, 2);
    check("rst_drain_en",        en_default, 1);
    cfg_access("rd_rst_status",   1'b0, REG_STATUS, 0, 32'h0, 1'b0);
    cfg_access("rd_rst_r0_start", 1'b0, REG_R0_START, 0, 32'h1080_0000, 1'b0);
    repeat (3) @(negedge clk);
    check("rst_quiet_block", req_block, 0);
    check("sb_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
